// File: rtl/fft_ctrl_pkg.sv
// Shared state encoding and sizing constants for the fft4 frame controller.
package fft_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int NUM_LANES      = 4;
   localparam int FRAME_CNT_W    = 16;

   // Bits needed for a counter holding 0..limit.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/fft4_frame_ctrl.sv
// Frame controller for a 4-point FFT datapath: gathers four samples, launches
// the fft4, waits (with timeout) for its result and streams the bins out in order.
module fft4_frame_ctrl
   import fft_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TIMEOUT    = 15
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [DATA_WIDTH-1:0]                s_real,
   input  logic [DATA_WIDTH-1:0]                s_imag,
   output logic                                 fft_en,
   output logic [NUM_LANES*DATA_WIDTH-1:0]      fft_in_real,
   output logic [NUM_LANES*DATA_WIDTH-1:0]      fft_in_imag,
   input  logic                                 fft_valid,
   input  logic [NUM_LANES*(DATA_WIDTH+2)-1:0]  fft_out_real,
   input  logic [NUM_LANES*(DATA_WIDTH+2)-1:0]  fft_out_imag,
   output logic                                 m_valid,
   input  logic                                 m_ready,
   output logic [DATA_WIDTH+1:0]                m_real,
   output logic [DATA_WIDTH+1:0]                m_imag,
   output logic [1:0]                           m_index,
   output logic                                 m_last,
   output logic                                 busy,
   output logic                                 err_timeout,
   output logic [FRAME_CNT_W-1:0]               frame_cnt
);

   localparam int RW = DATA_WIDTH + 2;
   localparam int TW = cnt_width(TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [1:0]               r_fill_cnt;
   logic [1:0]               r_drain_cnt;
   logic [TW-1:0]            r_timer;
   logic [FRAME_CNT_W-1:0]   r_frame_cnt;
   logic                     r_err_timeout;
   logic [DATA_WIDTH-1:0]    r_lane_re [NUM_LANES];
   logic [DATA_WIDTH-1:0]    r_lane_im [NUM_LANES];
   logic [RW-1:0]            r_res_re  [NUM_LANES];
   logic [RW-1:0]            r_res_im  [NUM_LANES];

   logic w_s_acc;
   logic w_m_acc;
   logic w_last_bin;
   logic w_capture;
   logic w_timeout;

   assign w_s_acc    = (r_state == ST_FILL) && s_valid;
   assign w_m_acc    = (r_state == ST_DRAIN) && m_ready;
   assign w_last_bin = (r_drain_cnt == 2'd3);
   assign w_capture  = (r_state == ST_WAIT) && fft_valid;
   // A result arriving on the last permitted WAIT cycle wins over the abort.
   assign w_timeout  = (r_state == ST_WAIT) && !fft_valid && (r_timer == TIMER_LAST);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_FILL: begin
            if (w_s_acc && (r_fill_cnt == 2'd3)) w_state_nxt = ST_LAUNCH;
            else                                 w_state_nxt = ST_FILL;
         end
         ST_LAUNCH: w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (w_capture)      w_state_nxt = ST_DRAIN;
            else if (w_timeout) w_state_nxt = ST_FILL;
            else                w_state_nxt = ST_WAIT;
         end
         ST_DRAIN: begin
            if (w_m_acc && w_last_bin) w_state_nxt = ST_FILL;
            else                       w_state_nxt = ST_DRAIN;
         end
         default: w_state_nxt = ST_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_FILL;
         r_fill_cnt    <= 2'd0;
         r_drain_cnt   <= 2'd0;
         r_timer       <= TW'(0);
         r_frame_cnt   <= 16'd0;
         r_err_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_err_timeout <= w_timeout;
         if (w_timeout)    r_fill_cnt <= 2'd0;
         else if (w_s_acc) r_fill_cnt <= r_fill_cnt + 2'd1;
         if ((r_state == ST_WAIT) && (w_state_nxt == ST_WAIT)) r_timer <= r_timer + TW'(1);
         else                                                  r_timer <= TW'(0);
         if (w_m_acc) r_drain_cnt <= r_drain_cnt + 2'd1;
         if (w_m_acc && w_last_bin) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   // Lanes are written only in FILL, so they hold through LAUNCH and WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            r_lane_re[k] <= DATA_WIDTH'(0);
            r_lane_im[k] <= DATA_WIDTH'(0);
            r_res_re[k]  <= RW'(0);
            r_res_im[k]  <= RW'(0);
         end
      end else begin
         if (w_s_acc) begin
            r_lane_re[r_fill_cnt] <= s_real;
            r_lane_im[r_fill_cnt] <= s_imag;
         end
         if (w_capture) begin
            for (int k = 0; k < NUM_LANES; k++) begin
               r_res_re[k] <= fft_out_real[k*RW +: RW];
               r_res_im[k] <= fft_out_imag[k*RW +: RW];
            end
         end
      end
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      assign fft_in_real[k*DATA_WIDTH +: DATA_WIDTH] = r_lane_re[k];
      assign fft_in_imag[k*DATA_WIDTH +: DATA_WIDTH] = r_lane_im[k];
   end

   assign s_ready     = (r_state == ST_FILL);
   assign fft_en      = (r_state == ST_LAUNCH);
   assign busy        = (r_state != ST_FILL);
   assign m_valid     = (r_state == ST_DRAIN);
   assign m_index     = r_drain_cnt;
   assign m_real      = r_res_re[r_drain_cnt];
   assign m_imag      = r_res_im[r_drain_cnt];
   assign m_last      = (r_state == ST_DRAIN) && w_last_bin;
   assign err_timeout = r_err_timeout;
   assign frame_cnt   = r_frame_cnt;

endmodule

// File: doc/fft4_frame_ctrl.md
FFT4_FRAME_CTRL -- requirements
Module: fft4_frame_ctrl

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8: input sample width; results are DATA_WIDTH+2 bits.
- TIMEOUT, default 15: maximum cycles in WAIT before abort.

REQ-002 Ports SHALL be (clock and reset first):
- clk  in  1  sole clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  controller accepts a sample.
- s_real, s_imag  in  DATA_WIDTH  signed sample.
- fft_en  out  1  launch pulse to the fft4 datapath.
- fft_in_real, fft_in_imag  out  4*DATA_WIDTH  lane k at [k*DATA_WIDTH +: DATA_WIDTH].
- fft_valid  in  1  fft4 result valid.
- fft_out_real, fft_out_imag  in  4*(DATA_WIDTH+2)  bin k at [k*(DATA_WIDTH+2) +: DATA_WIDTH+2].
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts a result.
- m_real, m_imag  out  DATA_WIDTH+2  signed bin value.
- m_index  out  2  bin number.
- m_last  out  1  high with bin 3.
- busy  out  1  state is not FILL.
- err_timeout  out  1  one-cycle abort pulse.
- frame_cnt  out  16  count of completed frames.

REQ-003 Clock is single and reset is synchronous, active-high, as stated in REQ-002.

Function
REQ-004 The FSM SHALL have states FILL, LAUNCH, WAIT, DRAIN.

REQ-005 FILL:
- s_ready=1.
- Each s_valid&s_ready stores the sample in lane fill_cnt and increments fill_cnt (2 bits).
- The accept at fill_cnt==3 moves to LAUNCH next cycle.
- Gaps in s_valid leave fill_cnt unchanged.

REQ-006 LAUNCH: fft_en=1 for exactly this one cycle, s_ready=0, then WAIT.

REQ-007 The fft_in lanes SHALL stay stable from LAUNCH until the FSM next leaves WAIT.

REQ-008 WAIT:
- s_ready=0; the timer counts cycles in WAIT, starting at 0.
- fft_valid=1 captures all four bins into result registers and moves to DRAIN.
- If the timer reaches TIMEOUT with no fft_valid: err_timeout=1 for one cycle, results are discarded, and the FSM returns to FILL with fill_cnt=0.

REQ-009 fft_valid asserted outside WAIT SHALL be ignored.

REQ-010 DRAIN:
- m_valid=1; m_index=drain_cnt; m_real/m_imag = captured bin drain_cnt; m_last=(drain_cnt==3).
- drain_cnt advances on m_valid&m_ready.
- The accept of bin 3 increments frame_cnt (wraps at 2^16-1 to 0) and returns to FILL.

REQ-011 While m_valid&!m_ready, m_real, m_imag, m_index and m_last SHALL hold stable.

REQ-012 The controller SHALL pass values through unmodified: no arithmetic on data, bins output in natural order 0..3.

REQ-013 s_ready SHALL be 0 in LAUNCH, WAIT and DRAIN; there is no frame overlap.

REQ-014 s_ready and m_valid SHALL be decoded from registered state only, with no combinational path from s_valid or m_ready.

Reset
REQ-015 While rst=1 (sampled at clk), the block SHALL enter FILL with:
- fill_cnt=0, drain_cnt=0, timer=0, frame_cnt=0.
- Lanes and result registers cleared to 0.

REQ-016 Output values during reset SHALL be s_ready=1, fft_en=0, m_valid=0, m_last=0, busy=0, err_timeout=0.

REQ-017 Reset asserted mid-frame (any state) SHALL abandon the frame, with no partial output and no frame_cnt increment.

Structure
REQ-018 Package fft_ctrl_pkg SHALL hold:
- the state enum;
- default DATA_WIDTH;
- the lane count constant 4;
- the frame_cnt width constant.

REQ-019 There SHALL be no sub-modules; fft4 is instantiated beside the controller at the next level up.

Verification
REQ-020 The bench SHALL cover these directed scenarios, with fft4 connected:
- Basic frame: samples (1,0),(2,0),(3,0),(4,0) back-to-back, m_ready=1 -> bins 0..3 = (10,0),(-2,2),(-2,0),(-2,-2); m_last on index 3; frame_cnt=1.
- Bubbles: s_valid toggling 1,0 -> same results; fft_en high exactly one cycle, one cycle after the 4th accept.
- Backpressure: m_ready low 5 cycles on bin 1 -> bin 1 held stable, no bin skipped or repeated.
- Timeout: fft_valid tied 0 -> err_timeout pulses TIMEOUT cycles after entering WAIT; m_valid never asserts; next frame completes normally.
- Reset mid-DRAIN after bin 1 -> m_valid=0 next cycle, frame_cnt unchanged, s_ready=1.
- Spurious fft_valid during FILL -> no m_valid; 100 random frames match the reference-model FFT.
